// File: rtl/dcache_pkg.sv
// Shared types for the data cache: FSM states, frame layout, flush-count address.
package dcache_pkg;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, LD0, LD1, FLUSH_CHK, FWB0, FWB1, FCNT, DONE
  } dcache_state_t;

  // Tag is kept as the address shifted right by 3+INDEX_W, zero-extended to
  // 32 bits, so the struct does not depend on the SETS parameter.
  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [31:0]      tag;
    logic [1:0][31:0] data;
  } dcache_frame_t;

  localparam logic [31:0] DCACHE_HITCNT_ADDR = 32'h0000_3100;

  // Rebuild a word address from a frame tag, index and word select.
  function automatic logic [31:0] blk_addr(input logic [31:0] tag, input logic [31:0] idx,
                                           input logic wsel, input int index_w);
    return (tag << (3 + index_w)) | (idx << 3) | {29'b0, wsel, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_frame_array.sv
// Frame storage: combinational read of one frame, one write port that can
// update the metadata (valid/dirty/tag) and/or one data word of that frame.
module dcache_frame_array
  import dcache_pkg::*;
#(
  parameter int SETS    = 16,
  parameter int INDEX_W = $clog2(SETS)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [INDEX_W-1:0] i_idx,
  output dcache_frame_t      o_frame,
  input  logic               i_wr_meta,
  input  logic               i_valid,
  input  logic               i_dirty,
  input  logic [31:0]        i_tag,
  input  logic               i_wr_word,
  input  logic               i_wsel,
  input  logic [31:0]        i_wdata
);

  dcache_frame_t r_frames [SETS];

  assign o_frame = r_frames[i_idx];

  // Reset invalidates every frame; otherwise apply the metadata and/or word write.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) r_frames[i] <= '0;
    end else begin
      if (i_wr_meta) begin
        r_frames[i_idx].valid <= i_valid;
        r_frames[i_idx].dirty <= i_dirty;
        r_frames[i_idx].tag   <= i_tag;
      end
      if (i_wr_word) r_frames[i_idx].data[i_wsel] <= i_wdata;
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache with flush-on-halt.
// Optional: define DCACHE_HITCNT_EN to count hit cycles and write the count
// to DCACHE_HITCNT_ADDR after the flush.
module dcache
  import dcache_pkg::*;
#(
  parameter int SETS      = 16,
  parameter int BLK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  localparam int INDEX_W = $clog2(SETS);
  localparam int WSEL_W  = $clog2(BLK_WORDS);

  dcache_state_t      r_state, w_next;
  logic [31:0]        r_addr;
  logic [INDEX_W-1:0] r_fidx;
  logic [INDEX_W-1:0] w_idx, w_req_idx, w_miss_idx;
  logic [31:0]        w_req_tag, w_miss_tag;
  dcache_frame_t      w_frame;
  logic               w_req, w_hit;
  logic               w_wr_meta, w_valid, w_dirty, w_wr_word;
  logic [31:0]        w_tag, w_wdata;
  logic [WSEL_W-1:0]  w_wsel;
`ifdef DCACHE_HITCNT_EN
  logic [31:0]        r_hitcnt;
`endif

  assign w_req_tag  = dmemaddr >> (3 + INDEX_W);
  assign w_req_idx  = INDEX_W'(dmemaddr >> 3);
  assign w_miss_tag = r_addr >> (3 + INDEX_W);
  assign w_miss_idx = INDEX_W'(r_addr >> 3);
  assign w_req      = dmemREN | dmemWEN;
  assign w_hit      = (r_state == IDLE) && w_req && w_frame.valid && (w_frame.tag == w_req_tag);

  // Frame index: live request in IDLE, flush pointer while flushing, latched miss otherwise.
  always_comb begin
    case (r_state)
      IDLE:                   w_idx = w_req_idx;
      FLUSH_CHK, FWB0, FWB1:  w_idx = r_fidx;
      default:                w_idx = w_miss_idx;
    endcase
  end

  dcache_frame_array #(.SETS(SETS), .INDEX_W(INDEX_W)) u_frames (
    .CLK(CLK), .nRST(nRST), .i_idx(w_idx), .o_frame(w_frame),
    .i_wr_meta(w_wr_meta), .i_valid(w_valid), .i_dirty(w_dirty), .i_tag(w_tag),
    .i_wr_word(w_wr_word), .i_wsel(w_wsel), .i_wdata(w_wdata)
  );

  // Next state, datapath response, memory port and frame write controls.
  always_comb begin
    w_next    = r_state;
    dhit      = 1'b0;
    dmemload  = '0;
    flushed   = 1'b0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    daddr     = '0;
    dstore    = '0;
    w_wr_meta = 1'b0;
    w_valid   = w_frame.valid;
    w_dirty   = w_frame.dirty;
    w_tag     = w_frame.tag;
    w_wr_word = 1'b0;
    w_wsel    = '0;
    w_wdata   = '0;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          dhit = 1'b1;
          if (dmemREN) dmemload = w_frame.data[dmemaddr[2]];
          if (dmemWEN) begin
            w_wr_meta = 1'b1;
            w_dirty   = 1'b1;
            w_wr_word = 1'b1;
            w_wsel    = dmemaddr[2];
            w_wdata   = dmemstore;
          end
        end else if (halt) begin
          w_next = FLUSH_CHK;
        end else if (w_req) begin
          w_next = (w_frame.valid && w_frame.dirty) ? WB0 : LD0;
        end
      end
      WB0, FWB0: begin
        dWEN   = 1'b1;
        daddr  = blk_addr(w_frame.tag, 32'(w_idx), 1'b0, INDEX_W);
        dstore = w_frame.data[0];
        if (!dwait) w_next = (r_state == WB0) ? WB1 : FWB1;
      end
      WB1, FWB1: begin
        dWEN   = 1'b1;
        daddr  = blk_addr(w_frame.tag, 32'(w_idx), 1'b1, INDEX_W);
        dstore = w_frame.data[1];
        if (!dwait) begin
          if (r_state == WB1) begin
            w_next = LD0;
          end else begin
            w_next    = FLUSH_CHK;
            w_wr_meta = 1'b1;
            w_dirty   = 1'b0;
          end
        end
      end
      LD0, LD1: begin
        dREN  = 1'b1;
        daddr = blk_addr(w_miss_tag, 32'(w_idx), r_state == LD1, INDEX_W);
        if (!dwait) begin
          w_wr_word = 1'b1;
          w_wsel    = WSEL_W'(r_state == LD1);
          w_wdata   = dload;
          w_next    = LD1;
          if (r_state == LD1) begin
            w_wr_meta = 1'b1;
            w_valid   = 1'b1;
            w_dirty   = 1'b0;
            w_tag     = w_miss_tag;
            w_next    = IDLE;
          end
        end
      end
      FLUSH_CHK: begin
        if (w_frame.valid && w_frame.dirty) w_next = FWB0;
`ifdef DCACHE_HITCNT_EN
        else if (r_fidx == INDEX_W'(SETS - 1)) w_next = FCNT;
`else
        else if (r_fidx == INDEX_W'(SETS - 1)) w_next = DONE;
`endif
      end
`ifdef DCACHE_HITCNT_EN
      FCNT: begin
        dWEN   = 1'b1;
        daddr  = DCACHE_HITCNT_ADDR;
        dstore = r_hitcnt;
        if (!dwait) w_next = DONE;
      end
`endif
      DONE:    flushed = 1'b1;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Latch the miss address and step the flush pointer past clean frames.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      r_addr <= '0;
      r_fidx <= '0;
    end else begin
      if (r_state == IDLE && (w_next == WB0 || w_next == LD0)) r_addr <= dmemaddr;
      if (r_state == FLUSH_CHK && w_next == FLUSH_CHK) r_fidx <= r_fidx + 1'b1;
    end
  end

`ifdef DCACHE_HITCNT_EN
  // Saturating count of hit cycles.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST)                        r_hitcnt <= '0;
    else if (dhit && r_hitcnt != '1)  r_hitcnt <= r_hitcnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: vector table of datapath accesses plus
// scripted flush and reset-abort sequences; memory traffic checked by a
// scoreboard queue of expected transfers.
module tb_dcache;

  logic        CLK = 0, nRST = 0;
  logic        dmemREN = 0, dmemWEN = 0, halt = 0;
  logic [31:0] dmemaddr = 0, dmemstore = 0;
  logic        dhit, flushed, dREN, dWEN, dwait;
  logic [31:0] dmemload, daddr, dstore;
  logic [31:0] dload = 0;

  dcache #(.SETS(16), .BLK_WORDS(2)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model + transfer scoreboard ----------------
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic [31:0] mem [logic [31:0]];
  xfer_t       exp_q[$];
  xfer_t       mon_e;
  int          wcnt;
  int          hits_seen;
  int          WAITC = 2;

  assign dwait = (dREN | dWEN) && (wcnt < WAITC);

  always @(posedge CLK or negedge nRST) begin
    if (!nRST)                     wcnt <= 0;
    else if ((dREN | dWEN) && dwait) wcnt <= wcnt + 1;
    else                           wcnt <= 0;
  end

  always @(negedge CLK) begin
    if (!nRST) hits_seen = 0;
    else if (dhit) hits_seen++;
    if (nRST && (dREN || dWEN) && !dwait) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_xfer: we=%0d addr=%h data=%h, none expected", dWEN, daddr, dstore);
      end else begin
        mon_e = exp_q.pop_front();
        chk("xfer_we", 32'(dWEN), 32'(mon_e.we));
        chk("xfer_addr", daddr, mon_e.addr);
        if (mon_e.we) chk("xfer_data", dstore, mon_e.data);
      end
      if (dWEN) mem[daddr] = dstore;
    end
    dload = mem.exists(daddr) ? mem[daddr] : 32'h0;
  end

  // One datapath access held until dhit; lat = cycles before dhit.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
    @(posedge CLK); #1;
    dmemREN = !wr; dmemWEN = wr; dmemaddr = a; dmemstore = wd; lat = 0;
    @(negedge CLK);
    while (!dhit && lat < 300) begin
      lat++;
      @(negedge CLK);
    end
    rd = dmemload;
    @(posedge CLK); #1;
    dmemREN = 0; dmemWEN = 0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          nx;
  } vec_t;

  vec_t        vt[$];
  xfer_t       xt[$];
  logic [31:0] rd;
  int          lat, xi, tmo;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mem[32'h40]  = 32'hAAAA_0001; mem[32'h44]  = 32'hAAAA_0002;
    mem[32'h440] = 32'hC0DE_0000; mem[32'h444] = 32'hC0DE_0004;
    mem[32'h88]  = 32'h1111_0088; mem[32'h8C]  = 32'h1111_008C;

    //          wr  addr      wdata         exp_rd        lat nx
    vt.push_back('{1'b0, 32'h40,  32'h0,      32'hAAAA_0001, 7,  2});
    vt.push_back('{1'b0, 32'h44,  32'h0,      32'hAAAA_0002, 0,  0});
    vt.push_back('{1'b1, 32'h44,  32'h1234,   32'h0,         0,  0});
    vt.push_back('{1'b0, 32'h44,  32'h0,      32'h1234,      0,  0});
    vt.push_back('{1'b0, 32'h440, 32'h0,      32'hC0DE_0000, 13, 4});
    vt.push_back('{1'b0, 32'h444, 32'h0,      32'hC0DE_0004, 0,  0});
    vt.push_back('{1'b1, 32'h88,  32'hBEEF,   32'h0,         7,  2});
    vt.push_back('{1'b0, 32'h88,  32'h0,      32'hBEEF,      0,  0});
    vt.push_back('{1'b0, 32'h8C,  32'h0,      32'h1111_008C, 0,  0});
    vt.push_back('{1'b1, 32'h444, 32'h5555,   32'h0,         0,  0});
    vt.push_back('{1'b0, 32'h444, 32'h0,      32'h5555,      0,  0});

    xt.push_back('{1'b0, 32'h40,  32'h0});
    xt.push_back('{1'b0, 32'h44,  32'h0});
    xt.push_back('{1'b1, 32'h40,  32'hAAAA_0001});
    xt.push_back('{1'b1, 32'h44,  32'h1234});
    xt.push_back('{1'b0, 32'h440, 32'h0});
    xt.push_back('{1'b0, 32'h444, 32'h0});
    xt.push_back('{1'b0, 32'h88,  32'h0});
    xt.push_back('{1'b0, 32'h8C,  32'h0});

    // Reset state
    #1;
    chk("rst_dhit", 32'(dhit), 32'd0);
    chk("rst_dREN", 32'(dREN), 32'd0);
    chk("rst_dWEN", 32'(dWEN), 32'd0);
    chk("rst_flushed", 32'(flushed), 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_dstore", dstore, 32'd0);
    chk("rst_dmemload", dmemload, 32'd0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1;

    // Table-driven accesses
    xi = 0;
    foreach (vt[i]) begin
      for (int k = 0; k < vt[i].nx; k++) begin
        exp_q.push_back(xt[xi]);
        xi++;
      end
      access(vt[i].wr, vt[i].addr, vt[i].wdata, rd, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
      if (!vt[i].wr) chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
    end
    chk("table_xfers_done", 32'(exp_q.size()), 32'd0);

    // Flush: dirty frames 1 and 8 written back in index order
    exp_q.push_back('{1'b1, 32'h88,  32'hBEEF});
    exp_q.push_back('{1'b1, 32'h8C,  32'h1111_008C});
    exp_q.push_back('{1'b1, 32'h440, 32'hC0DE_0000});
    exp_q.push_back('{1'b1, 32'h444, 32'h5555});
`ifdef DCACHE_HITCNT_EN
    exp_q.push_back('{1'b1, 32'h3100, 32'(hits_seen)});
`endif
    @(posedge CLK); #1 halt = 1;
    tmo = 0;
    @(negedge CLK);
    while (!flushed && tmo < 1000) begin
      tmo++;
      @(negedge CLK);
    end
    chk("flush_flushed", 32'(flushed), 32'd1);
    chk("flush_xfers_done", 32'(exp_q.size()), 32'd0);
    #1 dmemREN = 1; dmemaddr = 32'h40;
    repeat (8) begin
      @(negedge CLK);
      chk("done_dhit", 32'(dhit), 32'd0);
      chk("done_flushed_sticky", 32'(flushed), 32'd1);
    end

    // Reset, then abort a writeback mid-transfer
    #1 dmemREN = 0; halt = 0; nRST = 0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1;
    chk("rst2_flushed", 32'(flushed), 32'd0);
    exp_q.delete();
    exp_q.push_back('{1'b0, 32'h40, 32'h0});
    exp_q.push_back('{1'b0, 32'h44, 32'h0});
    access(1'b0, 32'h40, 32'h0, rd, lat);
    chk("ra_fill_lat", 32'(lat), 32'd7);
    chk("ra_fill_rd", rd, 32'hAAAA_0001);
    access(1'b1, 32'h40, 32'h7777, rd, lat);
    chk("ra_store_lat", 32'(lat), 32'd0);
    exp_q.push_back('{1'b1, 32'h40, 32'h7777});
    @(posedge CLK); #1 dmemREN = 1; dmemaddr = 32'h440;
    tmo = 0;
    @(negedge CLK);
    while (!(dWEN && daddr == 32'h44) && tmo < 100) begin
      tmo++;
      @(negedge CLK);
    end
    chk("ra_wb1_seen", 32'(dWEN && daddr == 32'h44), 32'd1);
    chk("ra_wb1_dwait", 32'(dwait), 32'd1);
    #2 nRST = 0;
    #1;
    chk("ra_abort_dWEN", 32'(dWEN), 32'd0);
    chk("ra_abort_dREN", 32'(dREN), 32'd0);
    chk("ra_abort_daddr", daddr, 32'd0);
    chk("ra_abort_flushed", 32'(flushed), 32'd0);
    chk("ra_abort_dhit", 32'(dhit), 32'd0);
    dmemREN = 0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1;
    chk("ra_wb0_only", 32'(exp_q.size()), 32'd0);
    exp_q.push_back('{1'b0, 32'h40, 32'h0});
    exp_q.push_back('{1'b0, 32'h44, 32'h0});
    access(1'b0, 32'h40, 32'h0, rd, lat);
    chk("ra_remiss_lat", 32'(lat), 32'd7);
    chk("ra_remiss_rd", rd, 32'h7777);
    chk("ra_xfers_done", 32'(exp_q.size()), 32'd0);

    repeat (3) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
